// File: rtl/com_rx_fifo.sv
// -----------------------------------------------------------------------------
// com_rx_fifo
// Receive-side byte FIFO between the UART async_receiver and serial_ctrl.
// Captures every rxdReady_i strobe into a circular buffer. serial_ctrl pops
// bytes on data-register reads. A level interrupt is raised on a fill
// threshold or after an idle timeout with data pending.
//
// Ports:
//   clk25           system clock (25 MHz)
//   rst             synchronous active-high reset
//   rxdReady_i      one-cycle strobe, rxdData_i valid
//   rxdData_i       received byte
//   popEnable_i     consume head byte this cycle
//   popData_o       head byte (first-word-fall-through), 8'h00 when empty
//   empty_o         FIFO holds no bytes
//   full_o          FIFO holds 2^DEPTH_LOG2 bytes
//   count_o         current occupancy
//   overflow_o      sticky: a byte was dropped while full
//   clearOverflow_i clears overflow_o
//   int_o           level interrupt: threshold or timeout
// -----------------------------------------------------------------------------
module com_rx_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int THRESHOLD      = 8,
    parameter int TIMEOUT_CYCLES = 104166
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic                  rxdReady_i,
    input  logic [7:0]            rxdData_i,
    input  logic                  popEnable_i,
    output logic [7:0]            popData_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  clearOverflow_i,
    output logic                  int_o
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] THRESH_CNT = (DEPTH_LOG2 + 1)'(THRESHOLD);
    localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  overflow;
    logic                  timeout_flag;
    logic [IDLE_W-1:0]     idle_cnt;

    logic empty;
    logic full;
    logic pop_acc;
    logic push_acc;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A push into a full FIFO is legal when a pop frees the head slot in
    // the same cycle; otherwise the byte is dropped.
    assign pop_acc  = popEnable_i & ~empty;
    assign push_acc = rxdReady_i & (~full | pop_acc);
    assign drop     = rxdReady_i & full & ~pop_acc;

    always_comb begin
        count_next = count;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is not reset; reset still blocks a write in the same cycle.
    always_ff @(posedge clk25) begin
        if (!rst && push_acc) begin
            mem[wr_ptr] <= rxdData_i;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            timeout_flag <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;

            // New drop event has priority over the clear request.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearOverflow_i) begin
                overflow <= 1'b0;
            end

            if (push_acc || pop_acc || empty) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // A push alone does not clear a pending timeout; a pop or the
            // FIFO draining does.
            if (pop_acc || (count_next == '0)) begin
                timeout_flag <= 1'b0;
            end else if ((idle_cnt == IDLE_MAX) && !empty) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign popData_o  = empty ? '0 : mem[rd_ptr];
    assign empty_o    = empty;
    assign full_o     = full;
    assign count_o    = count;
    assign overflow_o = overflow;
    assign int_o      = (count >= THRESH_CNT) | timeout_flag;

endmodule

// File: tb/tb_com_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_com_rx_fifo
// Self-checking bench for com_rx_fifo. A queue-based reference model tracks
// the expected contents, overflow, idle time and timeout state; every clock
// all outputs are compared against it, with extra directed checks at the
// threshold, full, overflow, timeout and reset boundaries, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_com_rx_fifo;

    localparam int DL2     = 4;
    localparam int DEPTH   = 1 << DL2;
    localparam int THRESH  = 8;
    localparam int TIMEOUT = 100;

    logic           clk25 = 1'b0;
    logic           rst = 1'b1;
    logic           rxdReady_i = 1'b0;
    logic [7:0]     rxdData_i = '0;
    logic           popEnable_i = 1'b0;
    logic [7:0]     popData_o;
    logic           empty_o;
    logic           full_o;
    logic [DL2:0]   count_o;
    logic           overflow_o;
    logic           clearOverflow_i = 1'b0;
    logic           int_o;

    com_rx_fifo #(
        .DEPTH_LOG2    (DL2),
        .THRESHOLD     (THRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk25          (clk25),
        .rst            (rst),
        .rxdReady_i     (rxdReady_i),
        .rxdData_i      (rxdData_i),
        .popEnable_i    (popEnable_i),
        .popData_o      (popData_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .clearOverflow_i(clearOverflow_i),
        .int_o          (int_o)
    );

    always #20 clk25 = ~clk25;

    int total = 0;
    int bad   = 0;

    // Reference model state
    byte unsigned q[$];
    bit           m_ovf   = 1'b0;
    int           m_idle  = 0;
    bit           m_tflag = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference model, from the inputs present at the edge.
    task automatic model_step();
        bit was_empty, was_full, pop_ok, push_ok, drop;
        int old_idle;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_idle  = 0;
            m_tflag = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            pop_ok    = popEnable_i && !was_empty;
            push_ok   = rxdReady_i && (!was_full || pop_ok);
            drop      = rxdReady_i && was_full && !pop_ok;
            old_idle  = m_idle;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(rxdData_i);
            if (drop) m_ovf = 1'b1;
            else if (clearOverflow_i) m_ovf = 1'b0;
            if (pop_ok || q.size() == 0) m_tflag = 1'b0;
            else if (old_idle >= TIMEOUT - 1 && !was_empty) m_tflag = 1'b1;
            if (push_ok || pop_ok || was_empty) m_idle = 0;
            else m_idle = (old_idle + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : old_idle + 1;
        end
    endtask

    task automatic compare_all();
        check("empty", empty_o, q.size() == 0);
        check("full", full_o, q.size() == DEPTH);
        check("count", count_o, q.size());
        check("popData", popData_o, (q.size() == 0) ? 8'h00 : q[0]);
        check("overflow", overflow_o, m_ovf);
        check("int", int_o, (q.size() >= THRESH) || m_tflag);
    endtask

    task automatic tick();
        @(posedge clk25);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r, input bit push, input byte unsigned d,
                         input bit pop, input bit clr);
        rst             = r;
        rxdReady_i      = push;
        rxdData_i       = d;
        popEnable_i     = pop;
        clearOverflow_i = clr;
    endtask

    task automatic step(input bit push, input byte unsigned d, input bit pop, input bit clr);
        drive(1'b0, push, d, pop, clr);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 2 * DEPTH) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        check("drain_empty", empty_o, 1'b1);
    endtask

    int pp, pq;

    initial begin
        // Reset and idle
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_count", count_o, 0);
        check("rst_data", popData_o, 8'h00);
        check("rst_int", int_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);

        // Three bytes in, then popped in order
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check("fwft_41", popData_o, 8'h41);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        check("cnt3", count_o, 3);
        check("head41", popData_o, 8'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("head42", popData_o, 8'h42);
        check("cnt2", count_o, 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("head43", popData_o, 8'h43);
        check("cnt1", count_o, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("cnt0", count_o, 0);
        check("empty_after3", empty_o, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);   // pop while empty: ignored
        check("pop_empty_cnt", count_o, 0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);   // push+pop while empty
        check("pp_empty_cnt", count_o, 1);
        drain();

        // Threshold interrupt
        for (int i = 0; i < THRESH; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            if (i == THRESH - 2) check("int_7th", int_o, 1'b0);
        end
        check("int_8th", int_o, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("int_after_pop", int_o, 1'b0);
        drain();

        // Overflow and full push+pop
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        check("full", full_o, 1'b1);
        check("full_cnt", count_o, DEPTH);
        check("ovf_set", overflow_o, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", overflow_o, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b1);   // drop with clear: drop wins
        check("ovf_prio", overflow_o, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        check("fullpp_cnt", count_o, DEPTH);
        check("fullpp_ovf", overflow_o, 1'b0);
        check("fullpp_head", popData_o, 8'h83);
        drain();

        // Idle timeout
        step(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("tmo_before", int_o, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("tmo_set", int_o, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("tmo_pop_int", int_o, 1'b0);
        check("tmo_pop_empty", empty_o, 1'b1);

        // Reset with simultaneous push
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rstpush_cnt", count_o, 0);
        check("rstpush_empty", empty_o, 1'b1);
        check("rstpush_int", int_o, 1'b0);
        check("rstpush_ovf", overflow_o, 1'b0);

        // Randomized phases against the model
        for (int ph = 0; ph < 15; ph++) begin
            case (ph % 5)
                0: begin pp = 50; pq = 0;  end
                1: begin pp = 50; pq = 30; end
                2: begin pp = 30; pq = 70; end
                3: begin pp = 0;  pq = 0;  end
                default: begin pp = 60; pq = 60; end
            endcase
            for (int c = 0; c < 200; c++) begin
                drive(($urandom_range(0, 499) == 0),
                      ($urandom_range(0, 99) < pp),
                      8'($urandom),
                      ($urandom_range(0, 99) < pq),
                      ($urandom_range(0, 19) == 0));
                tick();
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
